// File: rtl/gcn_stage_scheduler.sv
// ============================================================================
//  Module   : gcn_stage_scheduler
//  Purpose  : Top-level sequencer for the GCN datapath
//             (Transformation -> COO combination -> ArgMax). Issues one-cycle
//             start pulses, waits for each stage's done level, clears the
//             stages between graphs and walks NUM_GRAPHS graphs back to back,
//             advancing the FM/WM base address by GRAPH_STRIDE per graph.
//             A watchdog per WAIT state moves the block to ERROR when a
//             stage never answers.
//  Ports    : clk, reset (async, active-low)
//             start, abort                      - batch control
//             done_trans/done_comb/done_argmax  - stage done levels
//             start_trans/start_comb/start_argmax - 1-cycle stage kicks
//             stage_rst_n                       - 1-cycle stage clear
//             base_address, graph_idx           - graph in flight
//             busy, done, error, err_stage      - status
//             perf_cycles                       - batch cycle counter
//  Options  : GCN_SCHED_PERF_EN - enables the perf_cycles counter;
//             when undefined perf_cycles is tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gcn_stage_scheduler #(
  parameter int NUM_GRAPHS     = 4,
  parameter int GRAPH_BW       = ($clog2(NUM_GRAPHS) > 0) ? $clog2(NUM_GRAPHS) : 1,
  parameter int ADDRESS_WIDTH  = 13,
  parameter int GRAPH_STRIDE   = 102,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     done_trans,
  input  logic                     done_comb,
  input  logic                     done_argmax,
  output logic                     start_trans,
  output logic                     start_comb,
  output logic                     start_argmax,
  output logic                     stage_rst_n,
  output logic [ADDRESS_WIDTH-1:0] base_address,
  output logic [GRAPH_BW-1:0]      graph_idx,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [1:0]               err_stage,
  output logic [31:0]              perf_cycles
);

  localparam int                     c_WD_W       = $clog2(TIMEOUT_CYCLES);
  localparam logic [c_WD_W-1:0]      c_WD_LAST    = c_WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [c_WD_W-1:0]      c_WD_ONE     = c_WD_W'(1);
  localparam logic [GRAPH_BW-1:0]    c_LAST_GRAPH = GRAPH_BW'(NUM_GRAPHS - 1);
  localparam logic [GRAPH_BW-1:0]    c_IDX_ONE    = GRAPH_BW'(1);
  localparam logic [ADDRESS_WIDTH-1:0] c_STRIDE   = ADDRESS_WIDTH'(GRAPH_STRIDE);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_T_GO   = 4'd1,
    S_T_WAIT = 4'd2,
    S_C_GO   = 4'd3,
    S_C_WAIT = 4'd4,
    S_A_GO   = 4'd5,
    S_A_WAIT = 4'd6,
    S_NEXT   = 4'd7,
    S_DONE   = 4'd8,
    S_ERROR  = 4'd9
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [c_WD_W-1:0]        r_wd;
  logic                     w_timeout;
  logic                     w_in_wait;
  logic                     w_abort_take;
  logic                     w_restart;
  logic                     w_busy_nxt;
  logic [1:0]               w_err_stage_nxt;

  logic                     r_start_trans;
  logic                     r_start_comb;
  logic                     r_start_argmax;
  logic                     r_stage_rst_n;
  logic [ADDRESS_WIDTH-1:0] r_base_address;
  logic [GRAPH_BW-1:0]      r_graph_idx;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_error;
  logic [1:0]               r_err_stage;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_err_stage_nxt = r_err_stage;
    w_restart       = 1'b0;
    w_timeout       = (r_wd == c_WD_LAST);
    w_in_wait       = (r_state == S_T_WAIT) || (r_state == S_C_WAIT) ||
                      (r_state == S_A_WAIT);
    w_abort_take    = abort && (r_state != S_IDLE);

    // In every WAIT state the done level is tested before the timeout so
    // that a done arriving on the last allowed cycle still wins.
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_T_GO;
      S_T_GO:   w_state_nxt = S_T_WAIT;
      S_T_WAIT: begin
        if (done_trans) begin
          w_state_nxt = S_C_GO;
        end else if (w_timeout) begin
          w_state_nxt     = S_ERROR;
          w_err_stage_nxt = 2'd1;
        end
      end
      S_C_GO:   w_state_nxt = S_C_WAIT;
      S_C_WAIT: begin
        if (done_comb) begin
          w_state_nxt = S_A_GO;
        end else if (w_timeout) begin
          w_state_nxt     = S_ERROR;
          w_err_stage_nxt = 2'd2;
        end
      end
      S_A_GO:   w_state_nxt = S_A_WAIT;
      S_A_WAIT: begin
        if (done_argmax) begin
          w_state_nxt = (r_graph_idx == c_LAST_GRAPH) ? S_DONE : S_NEXT;
        end else if (w_timeout) begin
          w_state_nxt     = S_ERROR;
          w_err_stage_nxt = 2'd3;
        end
      end
      S_NEXT:   w_state_nxt = S_T_GO;
      S_DONE: begin
        if (start) begin
          w_state_nxt = S_T_GO;
          w_restart   = 1'b1;
        end
      end
      S_ERROR:  w_state_nxt = S_ERROR;
      default:  w_state_nxt = S_IDLE;
    endcase

    // Abort overrides whatever the stage/start inputs asked for.
    if (w_abort_take) begin
      w_state_nxt     = S_IDLE;
      w_err_stage_nxt = 2'd0;
      w_restart       = 1'b0;
    end

    w_busy_nxt = (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE) &&
                 (w_state_nxt != S_ERROR);
  end

  // --------------------------------------------------------------------------
  // State and registered (Moore) outputs, all decoded from the next state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_wd           <= '0;
      r_start_trans  <= 1'b0;
      r_start_comb   <= 1'b0;
      r_start_argmax <= 1'b0;
      r_stage_rst_n  <= 1'b1;
      r_base_address <= '0;
      r_graph_idx    <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_err_stage    <= 2'd0;
    end else begin
      r_state        <= w_state_nxt;
      // Every WAIT is entered from a GO state, where the watchdog sits at 0.
      r_wd           <= w_in_wait ? (r_wd + c_WD_ONE) : '0;
      r_start_trans  <= (w_state_nxt == S_T_GO);
      r_start_comb   <= (w_state_nxt == S_C_GO);
      r_start_argmax <= (w_state_nxt == S_A_GO);
      r_stage_rst_n  <= !((w_state_nxt == S_NEXT) || w_restart || w_abort_take);
      r_busy         <= w_busy_nxt;
      r_done         <= (w_state_nxt == S_DONE);
      r_error        <= (w_state_nxt == S_ERROR);
      r_err_stage    <= w_err_stage_nxt;

      if (w_abort_take || w_restart) begin
        r_graph_idx    <= '0;
        r_base_address <= '0;
      end else if (w_state_nxt == S_NEXT) begin
        r_graph_idx    <= r_graph_idx + c_IDX_ONE;
        r_base_address <= r_base_address + c_STRIDE;
      end
    end
  end

  assign start_trans  = r_start_trans;
  assign start_comb   = r_start_comb;
  assign start_argmax = r_start_argmax;
  assign stage_rst_n  = r_stage_rst_n;
  assign base_address = r_base_address;
  assign graph_idx    = r_graph_idx;
  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign err_stage    = r_err_stage;

  // --------------------------------------------------------------------------
  // Batch cycle counter
  // --------------------------------------------------------------------------
`ifdef GCN_SCHED_PERF_EN
  logic [31:0] r_perf;
  logic        w_accept;

  assign w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) &&
                    (w_state_nxt == S_T_GO);

  // The accepting cycle is counted, so a finished batch reports the same
  // number as the start-to-done latency. Counting stops once DONE/ERROR is
  // entered because busy is low there.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf <= '0;
    end else if (w_abort_take) begin
      r_perf <= '0;
    end else if (w_accept) begin
      r_perf <= 32'd1;
    end else if (r_busy && (r_perf != 32'hFFFF_FFFF)) begin
      r_perf <= r_perf + 32'd1;
    end
  end

  assign perf_cycles = r_perf;
`else
  assign perf_cycles = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gcn_stage_scheduler.sv
// ============================================================================
//  Module   : tb_gcn_stage_scheduler
//  Purpose  : Self-checking bench for gcn_stage_scheduler. Directed runs push
//             the expected stage pulses / status edges (with cycle, graph
//             index and base address) into a queue; a monitor pops and
//             compares whenever the DUT shows one of them.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gcn_stage_scheduler;

  localparam int NG     = 4;
  localparam int STRIDE = 102;
  localparam int TMO    = 16;

  localparam int K_RST   = 0;
  localparam int K_TRANS = 1;
  localparam int K_COMB  = 2;
  localparam int K_ARG   = 3;
  localparam int K_DONE  = 4;
  localparam int K_ERR   = 5;

`ifdef GCN_SCHED_PERF_EN
  localparam longint c_PERF_BATCH = 28;
  localparam longint c_PERF_START = 1;
`else
  localparam longint c_PERF_BATCH = 0;
  localparam longint c_PERF_START = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic        done_trans;
  logic        done_comb;
  logic        done_argmax;
  logic        start_trans;
  logic        start_comb;
  logic        start_argmax;
  logic        stage_rst_n;
  logic [12:0] base_address;
  logic [1:0]  graph_idx;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_stage;
  logic [31:0] perf_cycles;

  gcn_stage_scheduler #(
    .NUM_GRAPHS     (NG),
    .ADDRESS_WIDTH  (13),
    .GRAPH_STRIDE   (STRIDE),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .done_trans   (done_trans),
    .done_comb    (done_comb),
    .done_argmax  (done_argmax),
    .start_trans  (start_trans),
    .start_comb   (start_comb),
    .start_argmax (start_argmax),
    .stage_rst_n  (stage_rst_n),
    .base_address (base_address),
    .graph_idx    (graph_idx),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .err_stage    (err_stage),
    .perf_cycles  (perf_cycles)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // --------------------------------------------------------------------------
  // Stage models: done appears dly cycles after the start pulse cycle
  // (dly==0: never). A start clears any old done; stage_rst_n clears it too.
  // --------------------------------------------------------------------------
  int   dly_t, dly_c, dly_a;
  int   cnt_t, cnt_c, cnt_a;
  logic q_t, q_c, q_a;
  logic glitch_c;

  assign done_trans  = q_t;
  assign done_comb   = q_c | glitch_c;
  assign done_argmax = q_a;

  always @(posedge clk) begin
    if (!reset) begin q_t <= 1'b0; cnt_t <= 0; end
    else if (start_trans) begin q_t <= (dly_t == 1); cnt_t <= (dly_t > 1) ? dly_t - 1 : 0; end
    else if (!stage_rst_n) begin q_t <= 1'b0; cnt_t <= 0; end
    else if (cnt_t > 0) begin if (cnt_t == 1) q_t <= 1'b1; cnt_t <= cnt_t - 1; end
  end

  always @(posedge clk) begin
    if (!reset) begin q_c <= 1'b0; cnt_c <= 0; end
    else if (start_comb) begin q_c <= (dly_c == 1); cnt_c <= (dly_c > 1) ? dly_c - 1 : 0; end
    else if (!stage_rst_n) begin q_c <= 1'b0; cnt_c <= 0; end
    else if (cnt_c > 0) begin if (cnt_c == 1) q_c <= 1'b1; cnt_c <= cnt_c - 1; end
  end

  always @(posedge clk) begin
    if (!reset) begin q_a <= 1'b0; cnt_a <= 0; end
    else if (start_argmax) begin q_a <= (dly_a == 1); cnt_a <= (dly_a > 1) ? dly_a - 1 : 0; end
    else if (!stage_rst_n) begin q_a <= 1'b0; cnt_a <= 0; end
    else if (cnt_a > 0) begin if (cnt_a == 1) q_a <= 1'b1; cnt_a <= cnt_a - 1; end
  end

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  typedef struct {
    int     kind;
    int     cyc;
    int     idx;
    int     addr;
    longint aux;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic push(input int kind, input int c, input int idx, input int addr,
                      input longint aux);
    ev_t e;
    e.kind = kind; e.cyc = c; e.idx = idx; e.addr = addr; e.aux = aux;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input int kind, input longint aux);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind=%0d at cyc=%0d idx=%0d addr=%0d, expected none",
               kind, cyc, graph_idx, base_address);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.idx != int'(graph_idx) ||
          e.addr != int'(base_address) || e.aux != aux) begin
        n_fail++;
        $display("FAIL event: got kind=%0d cyc=%0d idx=%0d addr=%0d aux=%0d, expected kind=%0d cyc=%0d idx=%0d addr=%0d aux=%0d",
                 kind, cyc, graph_idx, base_address, aux,
                 e.kind, e.cyc, e.idx, e.addr, e.aux);
      end
    end
  endtask

  logic prev_done = 1'b0;
  logic prev_err  = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      prev_done = 1'b0;
      prev_err  = 1'b0;
    end else begin
      if (!stage_rst_n)         check_ev(K_RST, 0);
      if (start_trans)          check_ev(K_TRANS, 0);
      if (start_comb)           check_ev(K_COMB, 0);
      if (start_argmax)         check_ev(K_ARG, 0);
      if (done && !prev_done)   check_ev(K_DONE, longint'(perf_cycles));
      if (error && !prev_err)   check_ev(K_ERR, longint'(err_stage));
      prev_done = done;
      prev_err  = error;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cyc=%0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_start_trans"},  longint'(start_trans),  0);
    chk({tag, "_start_comb"},   longint'(start_comb),   0);
    chk({tag, "_start_argmax"}, longint'(start_argmax), 0);
    chk({tag, "_stage_rst_n"},  longint'(stage_rst_n),  1);
    chk({tag, "_base_address"}, longint'(base_address), 0);
    chk({tag, "_graph_idx"},    longint'(graph_idx),    0);
    chk({tag, "_busy"},         longint'(busy),         0);
    chk({tag, "_done"},         longint'(done),         0);
    chk({tag, "_error"},        longint'(error),        0);
    chk({tag, "_err_stage"},    longint'(err_stage),    0);
    chk({tag, "_perf"},         longint'(perf_cycles),  0);
  endtask

  // All drives happen at a negedge; an input set while cyc==c is sampled at
  // the edge that makes cyc==c+1.
  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic drive_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drive_abort();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  // Expected events of a full batch with every stage answering after 1 cycle.
  task automatic push_happy(input int s);
    for (int g = 0; g < NG; g++) begin
      push(K_TRANS, s + 7*g,     g, STRIDE*g, 0);
      push(K_COMB,  s + 7*g + 2, g, STRIDE*g, 0);
      push(K_ARG,   s + 7*g + 4, g, STRIDE*g, 0);
      if (g < NG - 1) push(K_RST, s + 7*g + 6, g + 1, STRIDE*(g + 1), 0);
    end
    push(K_DONE, s + 7*NG - 1, NG - 1, STRIDE*(NG - 1), c_PERF_BATCH);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int s;
    int a;
    reset = 1'b0; start = 1'b0; abort = 1'b0; glitch_c = 1'b0;
    dly_t = 1; dly_c = 1; dly_a = 1;
    repeat (3) @(negedge clk);
    chk_reset_vals("por");
    reset = 1'b1;
    @(negedge clk);

    // ---- Happy path, then restart from DONE, then abort from DONE ----
    s = cyc + 1;
    push_happy(s);
    drive_start();
    wait_cyc(s + 26);
    chk("done_not_early", longint'(done), 0);
    wait_cyc(s + 27);
    chk("done_at_28", longint'(done), 1);
    chk("busy_in_done", longint'(busy), 0);
    wait_cyc(s + 31);
    chk("done_held", longint'(done), 1);
    chk("perf_frozen", longint'(perf_cycles), c_PERF_BATCH);

    s = cyc + 1;
    push(K_RST, s, 0, 0, 0);
    push_happy(s);
    drive_start();
    chk("perf_restart", longint'(perf_cycles), c_PERF_START);
    chk("idx_restart", longint'(graph_idx), 0);
    wait_cyc(s + 28);
    a = cyc + 1;
    push(K_RST, a, 0, 0, 0);
    drive_abort();
    chk("done_after_abort", longint'(done), 0);
    chk("perf_after_abort", longint'(perf_cycles), 0);
    wait_cyc(a + 2);

    // ---- Comb stage never answers: watchdog ----
    dly_c = 0;
    s = cyc + 1;
    push(K_TRANS, s,     0, 0, 0);
    push(K_COMB,  s + 2, 0, 0, 0);
    push(K_ERR,   s + 2 + TMO + 1, 0, 0, 2);
    drive_start();
    wait_cyc(s + 2 + TMO);
    chk("no_error_before_timeout", longint'(error), 0);
    wait_cyc(s + 2 + TMO + 1);
    chk("error_set", longint'(error), 1);
    chk("err_stage_comb", longint'(err_stage), 2);
    chk("busy_in_error", longint'(busy), 0);
    drive_start();
    wait_cyc(cyc + 2);
    chk("error_held_start_ignored", longint'(error), 1);
    a = cyc + 1;
    push(K_RST, a, 0, 0, 0);
    drive_abort();
    chk("error_cleared", longint'(error), 0);
    chk("err_stage_cleared", longint'(err_stage), 0);
    dly_c = 1;
    wait_cyc(a + 2);

    // ---- Abort during T_WAIT of graph 2 ----
    dly_t = 3;
    s = cyc + 1;
    for (int g = 0; g < 2; g++) begin
      push(K_TRANS, s + 9*g,     g, STRIDE*g, 0);
      push(K_COMB,  s + 9*g + 4, g, STRIDE*g, 0);
      push(K_ARG,   s + 9*g + 6, g, STRIDE*g, 0);
      push(K_RST,   s + 9*g + 8, g + 1, STRIDE*(g + 1), 0);
    end
    push(K_TRANS, s + 18, 2, 2*STRIDE, 0);
    push(K_RST,   s + 20, 0, 0, 0);
    drive_start();
    wait_cyc(s + 19);
    chk("addr_graph2", longint'(base_address), 2*STRIDE);
    drive_abort();
    chk("busy_after_abort", longint'(busy), 0);
    chk("idx_after_abort", longint'(graph_idx), 0);
    chk("addr_after_abort", longint'(base_address), 0);
    wait_cyc(s + 23);
    dly_t = 1;

    // ---- Stray done_comb in T_WAIT; done_argmax on the timeout cycle ----
    dly_t = 5; dly_a = TMO;
    s = cyc + 1;
    push(K_TRANS, s,      0, 0, 0);
    push(K_COMB,  s + 6,  0, 0, 0);
    push(K_ARG,   s + 8,  0, 0, 0);
    push(K_RST,   s + 25, 1, STRIDE, 0);
    push(K_TRANS, s + 26, 1, STRIDE, 0);
    push(K_RST,   s + 27, 0, 0, 0);
    drive_start();
    wait_cyc(s + 1);
    glitch_c = 1'b1;
    wait_cyc(s + 4);
    glitch_c = 1'b0;
    wait_cyc(s + 25);
    chk("no_error_done_wins", longint'(error), 0);
    chk("busy_after_done_wins", longint'(busy), 1);
    wait_cyc(s + 26);
    drive_abort();
    dly_t = 1; dly_a = 1;
    wait_cyc(s + 29);

    // ---- Asynchronous reset in the middle of A_WAIT ----
    dly_a = 0;
    s = cyc + 1;
    push(K_TRANS, s,     0, 0, 0);
    push(K_COMB,  s + 2, 0, 0, 0);
    push(K_ARG,   s + 4, 0, 0, 0);
    drive_start();
    wait_cyc(s + 7);
    chk("busy_before_reset", longint'(busy), 1);
    #2 reset = 1'b0;
    #1 chk_reset_vals("async");
    @(negedge clk);
    reset = 1'b1;
    dly_a = 1;
    repeat (3) @(negedge clk);

    chk("scoreboard_drained", longint'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
